// File: rtl/usb_rx_crc_datapath_if.sv
// Bundle between the receive FSM (master) and the receive datapath (slave):
// FSM-driven shift/count/CRC controls plus the captured fields and CRC status.
interface usb_rx_crc_datapath_if #(
  parameter int PID_W  = 8,
  parameter int DATA_W = 64,
  parameter int CRC_W  = 16,
  parameter int CNT_W  = 7
);
  logic              s_in;
  logic              pid_en;
  logic              pid_left;
  logic              data_en;
  logic              data_left;
  logic              crc_en;
  logic              crc_left;
  logic              cnt_clr;
  logic              cnt_en;
  logic              crc16_start;
  logic              crc16_rec;
  logic [PID_W-1:0]  rc_hshake;
  logic [DATA_W-1:0] rc_data;
  logic [CRC_W-1:0]  rc_crc16;
  logic [CNT_W-1:0]  count;
  logic [15:0]       crc16_val;
  logic              crc16_out;
  logic              crc16_ready;
  logic              crc16_done;
  logic              crc_valid;

  modport master (
    output s_in, pid_en, pid_left, data_en, data_left, crc_en, crc_left,
           cnt_clr, cnt_en, crc16_start, crc16_rec,
    input  rc_hshake, rc_data, rc_crc16, count, crc16_val, crc16_out,
           crc16_ready, crc16_done, crc_valid
  );

  modport slave (
    input  s_in, pid_en, pid_left, data_en, data_left, crc_en, crc_left,
           cnt_clr, cnt_en, crc16_start, crc16_rec,
    output rc_hshake, rc_data, rc_crc16, count, crc16_val, crc16_out,
           crc16_ready, crc16_done, crc_valid
  );
endinterface

// File: rtl/usb_rx_crc_datapath.sv
// USB receive datapath: three serial-in shift registers (PID, DATA, CRC),
// a wrapping bit counter and a serial CRC16 engine. All sequencing decisions
// are made by the external receive FSM through the interface controls.

// Serial-in parallel-out register, shift direction selectable per cycle.
module usb_rx_sipo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         left_i,
  input  logic         s_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;

  // Left shift enters at the LSB, right shift enters at the MSB.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = left_i ? {q_q[W-2:0], s_i} : {s_i, q_q[W-1:1]};
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// Bit counter; clear has priority over increment, wraps naturally.
module usb_rx_counter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, increment or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// Serial CRC16 (x^16+x^15+x^2+1) over exactly DATA_W bits, with a
// start/done/acknowledge handshake toward the receive FSM.
module usb_rx_crc16 #(
  parameter int DATA_W = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_i,
  input  logic        start_i,
  input  logic        rec_i,
  output logic [15:0] val_o,
  output logic        out_o,
  output logic        ready_o,
  output logic        done_o
);
  localparam int BC_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [15:0]     r_q, r_d;
  logic [BC_W-1:0] bc_q, bc_d;

  function automatic logic [15:0] crc_step(input logic [15:0] r, input logic b);
    logic fb;
    fb = b ^ r[15];
    return {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  // State, remainder and bit-count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= 16'hFFFF;
      bc_q    <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      bc_q    <= bc_d;
    end
  end

  // Next state: the start cycle already folds in data bit 0, so RUN
  // handles the remaining DATA_W-1 bits and the last one enters DONE.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          r_d     = crc_step(16'hFFFF, s_i);
          bc_d    = BC_W'(1);
          state_d = RUN;
        end
      end
      RUN: begin
        r_d  = crc_step(r_q, s_i);
        bc_d = bc_q + BC_W'(1);
        if (bc_q == BC_W'(DATA_W - 1)) state_d = DONE;
      end
      DONE: begin
        if (rec_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: status from state, CRC value is the inverted remainder.
  always_comb begin
    ready_o = (state_q == IDLE);
    done_o  = (state_q == DONE);
    val_o   = ~r_q;
    out_o   = ~r_q[15];
  end
endmodule

// Top: wires the sub-blocks onto the FSM interface.
module usb_rx_crc_datapath #(
  parameter int PID_W  = 8,
  parameter int DATA_W = 64,
  parameter int CRC_W  = 16,
  parameter int CNT_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_rx_crc_datapath_if.slave  bus
);
  logic [15:0] crc_val_w;

  usb_rx_sipo #(.W(PID_W)) u_pid (
    .clk(clk), .rst(rst), .en_i(bus.pid_en), .left_i(bus.pid_left),
    .s_i(bus.s_in), .q_o(bus.rc_hshake)
  );

  usb_rx_sipo #(.W(DATA_W)) u_data (
    .clk(clk), .rst(rst), .en_i(bus.data_en), .left_i(bus.data_left),
    .s_i(bus.s_in), .q_o(bus.rc_data)
  );

  usb_rx_sipo #(.W(CRC_W)) u_crc (
    .clk(clk), .rst(rst), .en_i(bus.crc_en), .left_i(bus.crc_left),
    .s_i(bus.s_in), .q_o(bus.rc_crc16)
  );

  usb_rx_counter #(.W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .clr_i(bus.cnt_clr), .en_i(bus.cnt_en),
    .cnt_o(bus.count)
  );

  usb_rx_crc16 #(.DATA_W(DATA_W)) u_crc16 (
    .clk(clk), .rst(rst), .s_i(bus.s_in), .start_i(bus.crc16_start),
    .rec_i(bus.crc16_rec), .val_o(crc_val_w), .out_o(bus.crc16_out),
    .ready_o(bus.crc16_ready), .done_o(bus.crc16_done)
  );

  assign bus.crc16_val = crc_val_w;
  // Pure comparison; only meaningful while crc16_done is high.
  assign bus.crc_valid = (crc_val_w == 16'(bus.rc_crc16));
endmodule

// File: tb/tb_usb_rx_crc_datapath.sv
module tb_usb_rx_crc_datapath;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_rx_crc_datapath_if bus ();

  usb_rx_crc_datapath dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum int {S_HSK, S_DATA, S_CRC, S_CNT, S_VAL, S_OUT, S_RDY, S_DONE, S_VLD} sel_t;
  typedef struct {
    string       name;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hFEDCBA9876543210;

  function automatic logic [15:0] crc_model(input logic [63:0] d);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int i = 63; i >= 0; i--) begin
      if (d[i] ^ r[15]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return ~r;
  endfunction

  function automatic logic [63:0] peek(input sel_t s);
    case (s)
      S_HSK:  return 64'(bus.rc_hshake);
      S_DATA: return bus.rc_data;
      S_CRC:  return 64'(bus.rc_crc16);
      S_CNT:  return 64'(bus.count);
      S_VAL:  return 64'(bus.crc16_val);
      S_OUT:  return 64'(bus.crc16_out);
      S_RDY:  return 64'(bus.crc16_ready);
      S_DONE: return 64'(bus.crc16_done);
      default: return 64'(bus.crc_valid);
    endcase
  endfunction

  task automatic expect_v(input string n, input sel_t s, input logic [63:0] e);
    exp_t it;
    it.name = n; it.sel = s; it.exp = e;
    q.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every queued expectation away from the clock edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t it;
        logic [63:0] act;
        it = q.pop_front();
        act = peek(it.sel);
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.s_in = 0; bus.pid_en = 0; bus.pid_left = 0; bus.data_en = 0;
    bus.data_left = 0; bus.crc_en = 0; bus.crc_left = 0; bus.cnt_clr = 0;
    bus.cnt_en = 0; bus.crc16_start = 0; bus.crc16_rec = 0;
  endtask

  // Shift 64 data bits MSB-first with CRC start on bit 0; optional
  // second start pulse at index restart_at (must be ignored).
  task automatic send_data(input logic [63:0] d, input int restart_at, input string tag);
    for (int i = 0; i < 64; i++) begin
      bus.s_in = d[63-i];
      bus.data_en = 1; bus.data_left = 1;
      bus.crc16_start = (i == 0) || (i == restart_at);
      step();
      if (i == 0)  expect_v({tag, "_busy"}, S_RDY, 64'd0);
      if (i == 62) expect_v({tag, "_notdone63"}, S_DONE, 64'd0);
    end
    bus.data_en = 0; bus.crc16_start = 0;
    expect_v({tag, "_done64"}, S_DONE, 64'd1);
    expect_v({tag, "_data"}, S_DATA, d);
    expect_v({tag, "_val"}, S_VAL, 64'(crc_model(d)));
    expect_v({tag, "_out"}, S_OUT, 64'(crc_model(d) >> 15));
  endtask

  task automatic send_crc(input logic [15:0] c);
    bus.crc_en = 1; bus.crc_left = 1;
    for (int i = 15; i >= 0; i--) begin
      bus.s_in = c[i];
      step();
    end
    bus.crc_en = 0;
  endtask

  initial begin
    logic [7:0]  pid;
    logic [15:0] good;
    pid = 8'h4B;
    idle_inputs();
    rst = 1;
    step();
    expect_v("rst_count", S_CNT, 64'd0);
    expect_v("rst_hshake", S_HSK, 64'd0);
    expect_v("rst_data", S_DATA, 64'd0);
    expect_v("rst_crc", S_CRC, 64'd0);
    expect_v("rst_ready", S_RDY, 64'd1);
    expect_v("rst_done", S_DONE, 64'd0);
    expect_v("rst_val", S_VAL, 64'd0);
    rst = 0;

    // PID left (MSB-first) then right (LSB-first)
    bus.pid_en = 1; bus.pid_left = 1;
    for (int i = 7; i >= 0; i--) begin bus.s_in = pid[i]; step(); end
    expect_v("pid_left", S_HSK, 64'h4B);
    bus.pid_left = 0;
    for (int i = 0; i < 8; i++) begin bus.s_in = pid[i]; step(); end
    expect_v("pid_right", S_HSK, 64'h4B);
    bus.pid_en = 0;

    // Counter wrap
    bus.cnt_en = 1;
    for (int i = 1; i <= 130; i++) begin
      step();
      if (i == 127) expect_v("cnt_127", S_CNT, 64'd127);
      if (i == 128) expect_v("cnt_wrap0", S_CNT, 64'd0);
    end
    expect_v("cnt_130", S_CNT, 64'd2);
    bus.cnt_clr = 1;
    step();
    expect_v("cnt_clr_wins", S_CNT, 64'd0);
    bus.cnt_clr = 0; bus.cnt_en = 0;
    step();
    expect_v("cnt_hold", S_CNT, 64'd0);

    // Good packet
    good = crc_model(D1);
    send_data(D1, -1, "good");
    send_crc(good);
    expect_v("good_rxcrc", S_CRC, 64'(good));
    expect_v("good_valid", S_VLD, 64'd1);
    expect_v("good_data_hold", S_DATA, D1);
    expect_v("good_done_hold", S_DONE, 64'd1);
    bus.crc16_rec = 1; bus.crc16_start = 1;
    step();
    bus.crc16_rec = 0; bus.crc16_start = 0;
    expect_v("rec_wins_ready", S_RDY, 64'd1);
    expect_v("rec_wins_done", S_DONE, 64'd0);
    expect_v("idle_val_kept", S_VAL, 64'(good));
    step();
    expect_v("idle_stays", S_RDY, 64'd1);

    // Corrupted CRC
    send_data(D1, -1, "bad");
    send_crc(good ^ 16'h0400);
    expect_v("bad_valid", S_VLD, 64'd0);
    expect_v("bad_not_ready", S_RDY, 64'd0);
    bus.crc16_rec = 1;
    step();
    bus.crc16_rec = 0;
    expect_v("bad_rec_ready", S_RDY, 64'd1);

    // Reset mid-packet, with shift enables active (reset wins)
    for (int i = 0; i < 30; i++) begin
      bus.s_in = D2[63-i]; bus.data_en = 1; bus.data_left = 1;
      bus.crc16_start = (i == 0);
      step();
    end
    bus.crc16_start = 0;
    expect_v("mid_busy", S_RDY, 64'd0);
    rst = 1; bus.pid_en = 1; bus.s_in = 1;
    step();
    rst = 0; bus.pid_en = 0; bus.data_en = 0;
    expect_v("mid_rst_ready", S_RDY, 64'd1);
    expect_v("mid_rst_done", S_DONE, 64'd0);
    expect_v("mid_rst_val", S_VAL, 64'd0);
    expect_v("mid_rst_data", S_DATA, 64'd0);
    expect_v("mid_rst_pid", S_HSK, 64'd0);

    // Start during RUN ignored
    send_data(D2, 10, "restart");
    bus.crc16_rec = 1;
    step();
    bus.crc16_rec = 0;
    expect_v("restart_rec", S_RDY, 64'd1);

    // Drain scoreboard with a bound
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
